// File: rtl/gcd_host_driver.sv
// Host-side initiator for the subtractive GCD core: accepts operand pairs,
// sequences start/A/B onto the core's data bus, waits for done (with a
// timeout and stale-done guard) and returns the result over valid/ready.
module gcd_host_driver #(
    parameter int unsigned W              = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CW             = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [W-1:0]  req_a,
    input  logic [W-1:0]  req_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_gcd,
    output logic          rsp_bypass,
    output logic          rsp_timeout,
    output logic [CW-1:0] rsp_cycles,
    output logic          gcd_start,
    output logic [W-1:0]  gcd_data,
    input  logic          gcd_done,
    input  logic [W-1:0]  gcd_result
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  opnd_b_q, opnd_b_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          armed_q, armed_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_gcd_q, rsp_gcd_d;
    logic          rsp_bypass_q, rsp_bypass_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0] rsp_cycles_q, rsp_cycles_d;
    logic [CW-1:0] cycles_inc;
    logic          gcd_start_q, gcd_start_d;
    logic [W-1:0]  gcd_data_q, gcd_data_d;

    // Saturating increment of the operation cycle counter
    always_comb begin
        cycles_inc = (rsp_cycles_q == {CW{1'b1}}) ? rsp_cycles_q : rsp_cycles_q + CW'(1);
    end

    // Next-state and next-output decode; outputs are computed from the
    // destination state so that every port comes straight off a flop.
    // rsp_cycles counts every cycle spent in LOAD_A, LOAD_B and WAIT.
    always_comb begin
        state_d       = state_q;
        opnd_b_d      = opnd_b_q;
        tmo_d         = tmo_q;
        armed_d       = armed_q;
        rsp_gcd_d     = rsp_gcd_q;
        rsp_bypass_d  = rsp_bypass_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_cycles_d  = rsp_cycles_q;
        gcd_start_d   = 1'b0;
        gcd_data_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    opnd_b_d = req_b;
                    if ((req_a == '0) || (req_b == '0)) begin
                        // gcd(x,0)=x and gcd(0,0)=0; the core would never finish
                        state_d       = S_RESP;
                        rsp_gcd_d     = req_a | req_b;
                        rsp_bypass_d  = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_cycles_d  = '0;
                    end else begin
                        state_d       = S_LOAD_A;
                        rsp_bypass_d  = 1'b0;
                        rsp_timeout_d = 1'b0;
                        gcd_start_d   = 1'b1;
                        gcd_data_d    = req_a;
                    end
                end
            end
            S_LOAD_A: begin
                state_d      = S_LOAD_B;
                rsp_cycles_d = CW'(1);
                gcd_data_d   = opnd_b_q;
            end
            S_LOAD_B: begin
                state_d      = S_WAIT;
                rsp_cycles_d = cycles_inc;
                tmo_d        = '0;
                armed_d      = 1'b0;
            end
            S_WAIT: begin
                rsp_cycles_d = cycles_inc;
                armed_d      = armed_q | ~gcd_done;
                if (armed_q && gcd_done) begin
                    state_d       = S_RESP;
                    rsp_gcd_d     = gcd_result;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d       = S_RESP;
                    rsp_gcd_d     = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d       = S_IDLE;
                    rsp_bypass_d  = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            opnd_b_q      <= '0;
            tmo_q         <= '0;
            armed_q       <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_gcd_q     <= '0;
            rsp_bypass_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_cycles_q  <= '0;
            gcd_start_q   <= 1'b0;
            gcd_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            opnd_b_q      <= opnd_b_d;
            tmo_q         <= tmo_d;
            armed_q       <= armed_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_gcd_q     <= rsp_gcd_d;
            rsp_bypass_q  <= rsp_bypass_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_cycles_q  <= rsp_cycles_d;
            gcd_start_q   <= gcd_start_d;
            gcd_data_q    <= gcd_data_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_gcd     = rsp_gcd_q;
    assign rsp_bypass  = rsp_bypass_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_cycles  = rsp_cycles_q;
    assign gcd_start   = gcd_start_q;
    assign gcd_data    = gcd_data_q;

endmodule

// File: tb/tb_gcd_host_driver.sv
// Self-checking bench for gcd_host_driver with a behavioural subtractive GCD
// core attached, plus a forced-output core mode for timeout/stale-done cases.
module tb_gcd_host_driver;

    localparam int unsigned W   = 16;
    localparam int unsigned TMO = 16;
    localparam int unsigned CW  = 16;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_gcd;
    logic          rsp_bypass;
    logic          rsp_timeout;
    logic [CW-1:0] rsp_cycles;
    logic          gcd_start;
    logic [W-1:0]  gcd_data;
    logic          gcd_done;
    logic [W-1:0]  gcd_result;

    gcd_host_driver #(.W(W), .TIMEOUT_CYCLES(TMO), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_gcd     (rsp_gcd),
        .rsp_bypass  (rsp_bypass),
        .rsp_timeout (rsp_timeout),
        .rsp_cycles  (rsp_cycles),
        .gcd_start   (gcd_start),
        .gcd_data    (gcd_data),
        .gcd_done    (gcd_done),
        .gcd_result  (gcd_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural subtractive GCD core: start+A, then B, then iterate until equal
    logic [W-1:0] ca = '0;
    logic [W-1:0] cb = '0;
    logic [1:0]   ph = 2'd0;
    logic         m_done = 1'b0;
    always @(posedge clk) begin
        if (gcd_start) begin
            ca     <= gcd_data;
            ph     <= 2'd1;
            m_done <= 1'b0;
        end else if (ph == 2'd1) begin
            cb <= gcd_data;
            ph <= 2'd2;
        end else if (ph == 2'd2) begin
            if (ca == cb) begin
                m_done <= 1'b1;
                ph     <= 2'd0;
            end else if (ca > cb) begin
                ca <= ca - cb;
            end else begin
                cb <= cb - ca;
            end
        end
    end

    logic         forced;
    logic         f_done;
    logic [W-1:0] f_res;
    assign gcd_done   = forced ? f_done : m_done;
    assign gcd_result = forced ? f_res  : ca;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Euclid by remainder: reference result independent of the core's method
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Results of the most recent send()
    logic [W-1:0]  r_gcd;
    logic          r_byp;
    logic          r_tmo;
    logic [CW-1:0] r_cyc;
    int            r_cnt;
    int            r_starts;
    logic [W-1:0]  r_d0;
    logic [W-1:0]  r_d1;

    // Present one pair, then count cycles from LOAD_A until rsp_valid appears
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int  k;
        logic prev;
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        r_cnt = 0;
        r_starts = 0;
        r_d0 = '0;
        r_d1 = '0;
        prev = 1'b0;
        k = 0;
        while (!rsp_valid && k < 200) begin
            if (gcd_start) begin
                r_starts++;
                r_d0 = gcd_data;
            end
            if (prev) r_d1 = gcd_data;
            prev = gcd_start;
            r_cnt++;
            @(negedge clk);
            k++;
        end
        if (gcd_start) r_starts++;
        if (!rsp_valid) chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        r_gcd = rsp_gcd;
        r_byp = rsp_bypass;
        r_tmo = rsp_timeout;
        r_cyc = rsp_cycles;
    endtask

    // Complete the response handshake; req_ready must only rise afterwards
    task automatic handshake(input string name);
        chk({name, "_req_ready_in_resp"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, "_rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
        chk({name, "_req_ready_after_hs"}, 32'(req_ready), 32'd1);
    endtask

    task automatic check_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eg, input logic eb);
        send(a, b);
        chk({name, "_gcd"}, 32'(r_gcd), 32'(eg));
        chk({name, "_bypass"}, 32'(r_byp), 32'(eb));
        chk({name, "_timeout"}, 32'(r_tmo), 32'd0);
        chk({name, "_starts"}, 32'(r_starts), eb ? 32'd0 : 32'd1);
        if (!eb) begin
            chk({name, "_cycles"}, 32'(r_cyc), 32'(r_cnt));
            chk({name, "_data_a"}, 32'(r_d0), 32'(a));
            chk({name, "_data_b"}, 32'(r_d1), 32'(b));
        end else begin
            chk({name, "_latency"}, 32'(r_cnt), 32'd0);
        end
        handshake(name);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic         byp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int early;
        int seen;
        logic [W-1:0] a, b, g, hold_gcd;

        vecs[0] = '{a: 16'd143,  b: 16'd78,  g: 16'd13,  byp: 1'b0};
        vecs[1] = '{a: 16'd0,    b: 16'd5,   g: 16'd5,   byp: 1'b1};
        vecs[2] = '{a: 16'd7,    b: 16'd0,   g: 16'd7,   byp: 1'b1};
        vecs[3] = '{a: 16'd0,    b: 16'd0,   g: 16'd0,   byp: 1'b1};
        vecs[4] = '{a: 16'd48,   b: 16'd36,  g: 16'd12,  byp: 1'b0};
        vecs[5] = '{a: 16'd17,   b: 16'd51,  g: 16'd17,  byp: 1'b0};
        vecs[6] = '{a: 16'd9,    b: 16'd9,   g: 16'd9,   byp: 1'b0};
        vecs[7] = '{a: 16'd1000, b: 16'd250, g: 16'd250, byp: 1'b0};

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        forced = 1'b0;
        f_done = 1'b0;
        f_res = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_gcd", 32'(rsp_gcd), 32'd0);
        chk("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
        chk("rst_gcd_start", 32'(gcd_start), 32'd0);
        chk("rst_gcd_data", 32'(gcd_data), 32'd0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            check_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].byp);
        end

        // Randomised pairs with a bounded subtraction depth, some zero operands
        for (int i = 0; i < 40; i++) begin
            g = 16'($urandom_range(1, 4000));
            a = 16'(g * 16'($urandom_range(1, 4)));
            b = 16'(g * 16'($urandom_range(1, 4)));
            if ($urandom_range(0, 5) == 0) a = '0;
            if ($urandom_range(0, 5) == 0) b = '0;
            send(a, b);
            chk($sformatf("rnd%0d_gcd", i), 32'(r_gcd), 32'(ref_gcd(a, b)));
            chk($sformatf("rnd%0d_bypass", i), 32'(r_byp), 32'((a == '0) || (b == '0)));
            chk($sformatf("rnd%0d_timeout", i), 32'(r_tmo), 32'd0);
            if (!r_byp) chk($sformatf("rnd%0d_cycles", i), 32'(r_cyc), 32'(r_cnt));
            hold_gcd = r_gcd;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk($sformatf("rnd%0d_hold", i), 32'(rsp_gcd), 32'(hold_gcd));
            handshake($sformatf("rnd%0d", i));
        end

        // Backpressure with a second request waiting
        send(16'd48, 16'd36);
        req_valid = 1'b1;
        req_a = 16'd20;
        req_b = 16'd30;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_gcd", i), 32'(rsp_gcd), 32'd12);
            chk($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp_req_ready_after", 32'(req_ready), 32'd1);
        chk("bp_no_accept_in_hs", 32'(gcd_start), 32'd0);
        check_txn("bp_next", 16'd20, 16'd30, 16'd10, 1'b0);

        // Hung core: done never rises
        forced = 1'b1;
        f_done = 1'b0;
        send(16'd9, 16'd6);
        chk("tmo_flag", 32'(r_tmo), 32'd1);
        chk("tmo_gcd", 32'(r_gcd), 32'd0);
        chk("tmo_bypass", 32'(r_byp), 32'd0);
        chk("tmo_latency", 32'(r_cnt), 32'(TMO + 2));
        chk("tmo_cycles", 32'(r_cyc), 32'(TMO + 2));
        handshake("tmo");
        forced = 1'b0;
        check_txn("post_tmo", 16'd9, 16'd6, 16'd3, 1'b0);

        // Stale done held through load and the first WAIT cycle
        forced = 1'b1;
        f_done = 1'b1;
        f_res = 16'd99;
        @(negedge clk);
        req_valid = 1'b1;
        req_a = 16'd42;
        req_b = 16'd63;
        @(negedge clk);
        req_valid = 1'b0;
        early = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (rsp_valid) early++;
            if (k == 4) f_done = 1'b0;
            if (k == 6) begin
                f_done = 1'b1;
                f_res = 16'd21;
            end
        end
        @(negedge clk);
        chk("stale_early", 32'(early), 32'd0);
        chk("stale_valid", 32'(rsp_valid), 32'd1);
        chk("stale_gcd", 32'(rsp_gcd), 32'd21);
        chk("stale_cycles", 32'(rsp_cycles), 32'd6);
        handshake("stale");

        // Asynchronous reset while in WAIT
        f_done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_a = 16'd9;
        req_b = 16'd6;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_gcd", 32'(rsp_gcd), 32'd0);
        chk("arst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("arst_rsp_cycles", 32'(rsp_cycles), 32'd0);
        chk("arst_gcd_start", 32'(gcd_start), 32'd0);
        chk("arst_gcd_data", 32'(gcd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        forced = 1'b0;
        seen = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("arst_no_rsp", 32'(seen), 32'd0);
        check_txn("post_rst", 16'd17, 16'd51, 16'd17, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
